// File: rtl/arb_pkg.sv
// Shared definitions for the priority / round-robin arbiter.
package arb_pkg;

  // Arbitration mode encoding, as seen on the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // StIdle: no grant outstanding. StBusy: a requester holds the grant.
  typedef enum logic {
    StIdle,
    StBusy
  } arb_state_e;

  // Round-robin pointer after a grant to idx: one below the winner, wrapping to n-1.
  function automatic int unsigned ptr_dec(int unsigned idx, int unsigned n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Circular downward search: returns the first set bit of i_vec visiting
// i_start, i_start-1, ..., 0, N-1, ... Purely combinational.
module prio_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Walk the ring from the start pointer downwards; the first hit wins.
  always_comb begin
    int p;
    logic [W-1:0] w_pos;
    p       = 0;
    w_pos   = '0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      p = int'(i_start) - k;
      if (p < 0) begin
        p = p + int'(N);
      end
      w_pos = p[W-1:0];
      if (!o_found && i_vec[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter with fixed-priority (highest index wins) and round-robin modes.
// A grant is held while its request stays high; in round-robin mode a holder is
// rotated out after MAX_HOLD consecutive cycles if anyone else is waiting.
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  // With the limit disabled the counter is a 1-bit "has been granted" marker.
  localparam int unsigned      CntW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0]  CntSat = CntW'((MAX_HOLD > 0) ? MAX_HOLD : 1);
  localparam logic [N-1:0]     OneHot0 = {{(N-1){1'b0}}, 1'b1};

  arb_state_e      r_state;
  arb_state_e      w_state_d;
  logic [W-1:0]    r_ptr,       w_ptr_d;
  logic [CntW-1:0] r_cnt,       w_cnt_d;
  logic [N-1:0]    r_gnt,       w_gnt_d;
  logic [W-1:0]    r_gnt_idx,   w_gnt_idx_d;
  logic            r_gnt_valid, w_gnt_valid_d;
  // Mode in force when the current grant was issued; a later mode change only
  // takes effect at the next arbitration, so the hold limit follows this copy.
  logic            r_hold_mode, w_hold_mode_d;

  logic            w_holder_req;
  logic            w_others;
  logic            w_limit;
  logic            w_arb;
  logic [N-1:0]    w_vec;
  logic [W-1:0]    w_start;
  logic [W-1:0]    w_pick_idx;
  logic            w_pick_found;

  assign w_holder_req = req[r_gnt_idx];
  // The holder's own bit is excluded: in IDLE r_gnt is zero, so this is just req.
  assign w_vec        = req & ~r_gnt;
  assign w_others     = |w_vec;
  assign w_limit      = (MAX_HOLD > 0) && (r_hold_mode == MODE_RR) && (r_cnt == CntSat);
  assign w_arb        = (r_state == StIdle) || !w_holder_req || (w_limit && w_others);
  // Fixed priority is the same search started from the top index.
  assign w_start      = (mode == MODE_RR) ? r_ptr : W'(N - 1);

  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .i_vec  (w_vec),
    .i_start(w_start),
    .o_idx  (w_pick_idx),
    .o_found(w_pick_found)
  );

  // State register and all datapath registers; reset clears any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= W'(N - 1);
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_hold_mode <= MODE_FIXED;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_cnt       <= w_cnt_d;
      r_gnt       <= w_gnt_d;
      r_gnt_idx   <= w_gnt_idx_d;
      r_gnt_valid <= w_gnt_valid_d;
      r_hold_mode <= w_hold_mode_d;
    end
  end

  // Next state: any arbitration lands in BUSY if someone wins, else IDLE.
  always_comb begin
    w_state_d = r_state;
    if (w_arb) begin
      w_state_d = w_pick_found ? StBusy : StIdle;
    end
  end

  // Next grant, pointer and hold counter.
  always_comb begin
    w_ptr_d       = r_ptr;
    w_cnt_d       = r_cnt;
    w_gnt_d       = r_gnt;
    w_gnt_idx_d   = r_gnt_idx;
    w_gnt_valid_d = r_gnt_valid;
    w_hold_mode_d = r_hold_mode;
    if (w_arb) begin
      if (w_pick_found) begin
        w_gnt_d       = OneHot0 << w_pick_idx;
        w_gnt_idx_d   = w_pick_idx;
        w_gnt_valid_d = 1'b1;
        w_ptr_d       = W'(ptr_dec(32'(w_pick_idx), N));
        w_cnt_d       = CntW'(1);
        w_hold_mode_d = mode;
      end else begin
        w_gnt_d       = '0;
        w_gnt_idx_d   = '0;
        w_gnt_valid_d = 1'b0;
        w_cnt_d       = '0;
      end
    end else if (r_cnt != CntSat) begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=8, MAX_HOLD=4): directed scenarios
// with literal expectations plus a long random run against a behavioural model.
module tb_prio_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who holds the grant (-1 = nobody), rr pointer, hold count.
  int   m_hold;
  int   m_ptr;
  int   m_cnt;
  logic m_hmode;

  int pat [12] = '{2, 2, 2, 2, 0, 0, 0, 0, 2, 2, 2, 2};

  prio_arbiter #(
    .N(N),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mode     (mode),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First requester found walking start, start-1, ... around the ring.
  function automatic int search(input logic [7:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start - k + N) % N;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold  = -1;
    m_ptr   = N - 1;
    m_cnt   = 0;
    m_hmode = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] others;
    bit         arb;
    int         w;
    others = req;
    if (m_hold < 0) begin
      arb = 1'b1;
    end else begin
      others[m_hold] = 1'b0;
      if (!req[m_hold]) arb = 1'b1;
      else arb = (MAX_HOLD > 0) && m_hmode && (m_cnt >= MAX_HOLD) && (others != 0);
    end
    if (arb) begin
      w = search(others, mode ? m_ptr : N - 1);
      if (w >= 0) begin
        m_hold  = w;
        m_ptr   = (w + N - 1) % N;
        m_cnt   = 1;
        m_hmode = mode;
      end else begin
        m_hold = -1;
        m_cnt  = 0;
      end
    end else if (m_cnt < MAX_HOLD) begin
      m_cnt++;
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Advance the model on each edge and compare the registered outputs just after.
  always @(posedge clk) begin
    if (rst_n === 1'b1) model_step();
    #1;
    chk("model_gnt", int'(gnt), (m_hold >= 0) ? (1 << m_hold) : 0);
    chk("model_idx", int'(gnt_idx), (m_hold >= 0) ? m_hold : 0);
    chk("model_valid", int'(gnt_valid), (m_hold >= 0) ? 1 : 0);
  end

  // Apply inputs on the falling edge, return just after the following rising edge.
  task automatic cyc(input logic [7:0] r, input logic m);
    @(negedge clk);
    req  = r;
    mode = m;
    @(posedge clk);
    #2;
  endtask

  // Assert reset between edges, check the asynchronous clear, then release with r/m applied.
  task automatic do_reset(input logic [7:0] r, input logic m);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    req  = r;
    mode = m;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] r;
    logic       m;
    r = '0;
    m = 1'b0;
    model_reset();
    rst_n = 1'b0;
    req   = '0;
    mode  = 1'b0;
    #3;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_idx", int'(gnt_idx), 0);
    chk("reset_valid", int'(gnt_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority picks the highest index.
    cyc(8'b00110010, 1'b0);
    chk("fixed_gnt", int'(gnt), 8'b00100000);
    chk("fixed_idx", int'(gnt_idx), 5);
    chk("fixed_valid", int'(gnt_valid), 1);
    cyc(8'b00000000, 1'b0);
    chk("fixed_release", int'(gnt_valid), 0);

    // Held grant, then drop to idle.
    repeat (4) begin
      cyc(8'b00000010, 1'b0);
      chk("hold_idx", int'(gnt_idx), 1);
      chk("hold_valid", int'(gnt_valid), 1);
    end
    cyc(8'b00000000, 1'b0);
    chk("drop_valid", int'(gnt_valid), 0);
    chk("drop_gnt", int'(gnt), 0);

    // Round-robin hold-limit rotation from a fresh pointer.
    do_reset(8'b00000101, 1'b1);
    chk("rr_rot_0", int'(gnt_idx), pat[0]);
    for (int i = 1; i < 12; i++) begin
      cyc(8'b00000101, 1'b1);
      chk("rr_rot", int'(gnt_idx), pat[i]);
    end
    cyc(8'b00000000, 1'b1);

    // Sole requester keeps the grant past the limit.
    repeat (10) begin
      cyc(8'b00000001, 1'b1);
      chk("sat_idx", int'(gnt_idx), 0);
      chk("sat_valid", int'(gnt_valid), 1);
    end
    cyc(8'b00000000, 1'b1);

    // Reset mid-grant, first arbitration after release uses pointer N-1.
    cyc(8'b00010000, 1'b0);
    chk("pre_rst_idx", int'(gnt_idx), 4);
    do_reset(8'b10000001, 1'b1);
    chk("post_rst_idx", int'(gnt_idx), 7);
    chk("post_rst_valid", int'(gnt_valid), 1);
    cyc(8'b00000000, 1'b1);

    // Holder drops while two others request: no idle gap, in both modes.
    cyc(8'b01001000, 1'b0);
    chk("handoff_fixed_a", int'(gnt_idx), 6);
    cyc(8'b00001001, 1'b0);
    chk("handoff_fixed_b", int'(gnt_idx), 3);
    chk("handoff_fixed_v", int'(gnt_valid), 1);
    cyc(8'b00000000, 1'b1);
    cyc(8'b01001000, 1'b1);
    chk("handoff_rr_a", int'(gnt_idx), 6);
    cyc(8'b00001001, 1'b1);
    chk("handoff_rr_b", int'(gnt_idx), 3);
    chk("handoff_rr_v", int'(gnt_valid), 1);

    // Random traffic with sticky requests, occasional mode flips and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) r = r & ~gnt;
      if ($urandom_range(0, 15) == 0) m = ~m;
      if ($urandom_range(0, 499) == 0) do_reset(r, m);
      else cyc(r, m);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
